// File: rtl/link_sync_ctrl_pkg.sv
// Shared types and default parameters for the link sync controller.
// State encoding plus the comma/lock/slip timing defaults.
package link_sync_ctrl_pkg;

    typedef enum logic [1:0] {
        S_HUNT  = 2'd0,
        S_SLIP  = 2'd1,
        S_CHECK = 2'd2,
        S_SYNC  = 2'd3
    } state_e;

    localparam logic [7:0] DEF_COMMA     = 8'hBC;
    localparam int         DEF_N_LOCK    = 4;
    localparam int         DEF_MAX_RUN   = 64;
    localparam int         DEF_SLIP_TO   = 16;
    localparam int         DEF_SLIP_WAIT = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the link loss statistic.
// Sticks at all-ones once reached.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // increment unless already at the ceiling
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
    end

    // count register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/link_sync_ctrl.sv
// Byte-stream comma alignment and lock controller.
// Hunts for commas, slips bit alignment, and tracks loss of sync.
module link_sync_ctrl
    import link_sync_ctrl_pkg::*;
#(
    parameter logic [7:0] COMMA     = DEF_COMMA,
    parameter int         N_LOCK    = DEF_N_LOCK,
    parameter int         MAX_RUN   = DEF_MAX_RUN,
    parameter int         SLIP_TO   = DEF_SLIP_TO,
    parameter int         SLIP_WAIT = DEF_SLIP_WAIT
) (
    input  logic       clk_f,
    input  logic       reset_L,
    input  logic [7:0] byte_in,
    input  logic       resync,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       bit_slip,
    output logic       locked,
    output logic [7:0] loss_cnt
);

    localparam int MW = $clog2(SLIP_TO + 1);
    localparam int WW = $clog2(SLIP_WAIT + 1);
    localparam int CW = $clog2(N_LOCK + 1);
    localparam int RW = $clog2(MAX_RUN + 1);

    state_e        state_q, state_d;
    logic [MW-1:0] miss_q, miss_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [CW-1:0] comma_q, comma_d;
    logic [RW-1:0] run_q, run_d;
    logic [7:0]    data_q;
    logic          valid_q, valid_d;
    logic          is_comma;
    logic          slip;
    logic          loss_inc;

    assign is_comma = (byte_in == COMMA);

    // next-state, counter updates and the Mealy slip/loss strobes
    always_comb begin
        state_d  = state_q;
        miss_d   = miss_q;
        wait_d   = wait_q;
        comma_d  = comma_q;
        run_d    = run_q;
        slip     = 1'b0;
        loss_inc = 1'b0;
        if (resync) begin
            state_d  = S_HUNT;
            miss_d   = '0;
            wait_d   = '0;
            comma_d  = '0;
            run_d    = '0;
            loss_inc = (state_q == S_SYNC);
        end else begin
            unique case (state_q)
                S_HUNT: begin
                    if (is_comma) begin
                        state_d = S_CHECK;
                        comma_d = CW'(1);
                        miss_d  = '0;
                    end else if (miss_q == MW'(SLIP_TO - 1)) begin
                        state_d = S_SLIP;
                        slip    = 1'b1;
                        miss_d  = '0;
                    end else begin
                        miss_d = miss_q + MW'(1);
                    end
                end
                S_SLIP: begin
                    if (wait_q == WW'(SLIP_WAIT - 1)) begin
                        state_d = S_HUNT;
                        wait_d  = '0;
                        miss_d  = '0;
                    end else begin
                        wait_d = wait_q + WW'(1);
                    end
                end
                S_CHECK: begin
                    if (!is_comma) begin
                        state_d = S_HUNT;
                        comma_d = '0;
                        miss_d  = '0;
                    end else if (comma_q == CW'(N_LOCK - 1)) begin
                        state_d = S_SYNC;
                        comma_d = '0;
                        run_d   = '0;
                    end else begin
                        comma_d = comma_q + CW'(1);
                    end
                end
                S_SYNC: begin
                    if (is_comma) begin
                        run_d = '0;
                    end else if (run_q == RW'(MAX_RUN)) begin
                        state_d  = S_HUNT;
                        run_d    = '0;
                        loss_inc = 1'b1;
                    end else begin
                        run_d = run_q + RW'(1);
                    end
                end
                default: state_d = S_HUNT;
            endcase
        end
    end

    // payload qualifies only if it stays in SYNC and is not a comma
    always_comb begin
        valid_d = (state_q == S_SYNC) && !is_comma && (state_d == S_SYNC);
    end

    // state, counters and the one-cycle-delayed payload
    always_ff @(posedge clk_f or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= S_HUNT;
            miss_q  <= '0;
            wait_q  <= '0;
            comma_q <= '0;
            run_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            miss_q  <= miss_d;
            wait_q  <= wait_d;
            comma_q <= comma_d;
            run_q   <= run_d;
            data_q  <= byte_in;
            valid_q <= valid_d;
        end
    end

    sat_counter #(
        .W(8)
    ) u_loss (
        .clk_i (clk_f),
        .rst_ni(reset_L),
        .inc_i (loss_inc),
        .cnt_o (loss_cnt)
    );

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign bit_slip  = slip;
    assign locked    = (state_q == S_SYNC);

endmodule

// File: tb/tb_link_sync_ctrl.sv
// Directed bench for link_sync_ctrl.
// Table of lock/resync vectors plus hand sequences for slip, run and loss.
module tb_link_sync_ctrl;

    logic       clk_f   = 1'b0;
    logic       reset_L = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       resync  = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       bit_slip;
    logic       locked;
    logic [7:0] loss_cnt;

    int   vecs = 0;
    int   errs = 0;
    logic slip_s;

    typedef struct {
        logic [7:0] b;
        logic       rs;
        logic [7:0] d;
        logic       v;
        logic       lk;
        logic [7:0] loss;
    } vec_t;

    vec_t tbl [18];

    always #5 clk_f = ~clk_f;

    link_sync_ctrl dut (
        .clk_f    (clk_f),
        .reset_L  (reset_L),
        .byte_in  (byte_in),
        .resync   (resync),
        .data_out (data_out),
        .valid_out(valid_out),
        .bit_slip (bit_slip),
        .locked   (locked),
        .loss_cnt (loss_cnt)
    );

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    // called at a negedge; returns at the following negedge
    task automatic cyc(input logic [7:0] b, input logic rs);
        byte_in = b;
        resync  = rs;
        #1;
        slip_s = bit_slip;
        @(posedge clk_f);
        #1;
        @(negedge clk_f);
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        byte_in = 8'h00;
        resync  = 1'b0;
        repeat (2) @(negedge clk_f);
        reset_L = 1'b1;
    endtask

    task automatic lock_up();
        for (int k = 0; k < 4; k++) cyc(8'hBC, 1'b0);
    endtask

    initial begin
        tbl[0]  = '{8'hBC, 1'b0, 8'hBC, 1'b0, 1'b0, 8'd0};
        tbl[1]  = '{8'hBC, 1'b0, 8'hBC, 1'b0, 1'b0, 8'd0};
        tbl[2]  = '{8'hBC, 1'b0, 8'hBC, 1'b0, 1'b0, 8'd0};
        tbl[3]  = '{8'hBC, 1'b0, 8'hBC, 1'b0, 1'b1, 8'd0};
        tbl[4]  = '{8'h55, 1'b0, 8'h55, 1'b1, 1'b1, 8'd0};
        tbl[5]  = '{8'hBC, 1'b0, 8'hBC, 1'b0, 1'b1, 8'd0};
        tbl[6]  = '{8'hA5, 1'b0, 8'hA5, 1'b1, 1'b1, 8'd0};
        tbl[7]  = '{8'h66, 1'b1, 8'h66, 1'b0, 1'b0, 8'd1};
        tbl[8]  = '{8'h66, 1'b1, 8'h66, 1'b0, 1'b0, 8'd1};
        tbl[9]  = '{8'hBC, 1'b0, 8'hBC, 1'b0, 1'b0, 8'd1};
        tbl[10] = '{8'hBC, 1'b0, 8'hBC, 1'b0, 1'b0, 8'd1};
        tbl[11] = '{8'hBC, 1'b0, 8'hBC, 1'b0, 1'b0, 8'd1};
        tbl[12] = '{8'hA0, 1'b0, 8'hA0, 1'b0, 1'b0, 8'd1};
        tbl[13] = '{8'hBC, 1'b0, 8'hBC, 1'b0, 1'b0, 8'd1};
        tbl[14] = '{8'hBC, 1'b0, 8'hBC, 1'b0, 1'b0, 8'd1};
        tbl[15] = '{8'hBC, 1'b0, 8'hBC, 1'b0, 1'b0, 8'd1};
        tbl[16] = '{8'hBC, 1'b0, 8'hBC, 1'b0, 1'b1, 8'd1};
        tbl[17] = '{8'hBC, 1'b0, 8'hBC, 1'b0, 1'b1, 8'd1};

        // reset state
        do_reset();
        chk("rst data", data_out, 8'h00);
        chk("rst valid", valid_out, 1'b0);
        chk("rst slip", bit_slip, 1'b0);
        chk("rst locked", locked, 1'b0);
        chk("rst loss", loss_cnt, 8'h00);

        // lock, payload, resync, false-lock recovery
        for (int i = 0; i < 18; i++) begin
            cyc(tbl[i].b, tbl[i].rs);
            chk($sformatf("t%0d data", i), data_out, tbl[i].d);
            chk($sformatf("t%0d valid", i), valid_out, tbl[i].v);
            chk($sformatf("t%0d locked", i), locked, tbl[i].lk);
            chk($sformatf("t%0d loss", i), loss_cnt, tbl[i].loss);
            chk($sformatf("t%0d slip", i), slip_s, 1'b0);
        end

        // slip after 16 misses, then 8 ignored cycles
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cyc(8'h17, 1'b0);
            chk($sformatf("miss%0d slip", i), slip_s, (i == 15));
        end
        for (int i = 0; i < 8; i++) begin
            cyc(8'hBC, 1'b0);
            chk($sformatf("wait%0d slip", i), slip_s, 1'b0);
            chk($sformatf("wait%0d locked", i), locked, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(8'hBC, 1'b0);
            chk($sformatf("relock%0d", i), locked, (i == 3));
        end

        // run limit: 64 payload ok, comma resets, 65th drops lock
        do_reset();
        lock_up();
        chk("run lock", locked, 1'b1);
        chk("run loss0", loss_cnt, 8'd0);
        for (int i = 0; i < 64; i++) begin
            cyc(8'h3C, 1'b0);
            chk($sformatf("runA%0d valid", i), valid_out, 1'b1);
            chk($sformatf("runA%0d data", i), data_out, 8'h3C);
        end
        cyc(8'hBC, 1'b0);
        chk("run comma valid", valid_out, 1'b0);
        chk("run comma locked", locked, 1'b1);
        for (int i = 0; i < 64; i++) begin
            cyc(8'h3C, 1'b0);
            chk($sformatf("runB%0d valid", i), valid_out, 1'b1);
        end
        chk("run64 locked", locked, 1'b1);
        cyc(8'h3C, 1'b0);
        chk("run65 valid", valid_out, 1'b0);
        chk("run65 locked", locked, 1'b0);
        chk("run65 loss", loss_cnt, 8'd1);

        // loss counter saturation
        do_reset();
        for (int i = 0; i < 300; i++) begin
            lock_up();
            cyc(8'h55, 1'b1);
            if (i == 0)   chk("sat 1", loss_cnt, 8'd1);
            if (i == 253) chk("sat 254", loss_cnt, 8'd254);
            if (i == 254) chk("sat 255", loss_cnt, 8'd255);
            if (i == 299) chk("sat hold", loss_cnt, 8'hFF);
        end

        // async reset mid-payload
        lock_up();
        cyc(8'h55, 1'b0);
        chk("pre-rst valid", valid_out, 1'b1);
        #2;
        reset_L = 1'b0;
        #1;
        chk("arst data", data_out, 8'h00);
        chk("arst valid", valid_out, 1'b0);
        chk("arst locked", locked, 1'b0);
        chk("arst loss", loss_cnt, 8'h00);
        chk("arst slip", bit_slip, 1'b0);
        repeat (2) @(negedge clk_f);
        reset_L = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(8'hBC, 1'b0);
            chk($sformatf("post%0d locked", i), locked, (i == 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
